// File: rtl/video_pkg.sv
// Video constants and pattern index definitions shared by the pixel pipeline
// and the controllers that drive it.
package video_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  localparam int PAT_W = 3;

  localparam logic [PAT_W-1:0] PAT_COLOR_BARS = 3'd0;
  localparam logic [PAT_W-1:0] PAT_GRADIENT   = 3'd1;
  localparam logic [PAT_W-1:0] PAT_CHECKER    = 3'd2;
  localparam logic [PAT_W-1:0] PAT_GRID       = 3'd3;

  typedef enum logic [1:0] {
    DB_RELEASED     = 2'd0,
    DB_PRESS_WAIT   = 2'd1,
    DB_PRESSED      = 2'd2,
    DB_RELEASE_WAIT = 2'd3
  } db_state_e;

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer plus a four-state debounce FSM; emits a single-cycle
// pulse when a press has been stable for DEBOUNCE_CYCLES synchronized cycles.
module button_debounce
  import video_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          btn_sync;
  db_state_e     state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_inc;
  logic          press_q;

  assign btn_sync = sync_q[1];
  assign cnt_inc  = cnt_q + 1'b1;
  assign press_o  = press_q;

  // The cycle that enters a WAIT state counts as the first stable cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      state_q <= DB_RELEASED;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_n};
      press_q <= 1'b0;
      case (state_q)
        DB_RELEASED: begin
          if (!btn_sync) begin
            state_q <= DB_PRESS_WAIT;
            cnt_q   <= '0;
          end
        end
        DB_PRESS_WAIT: begin
          if (btn_sync) begin
            state_q <= DB_RELEASED;
          end else if (cnt_inc == CNT_LAST) begin
            state_q <= DB_PRESSED;
            press_q <= 1'b1;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        DB_PRESSED: begin
          if (btn_sync) begin
            state_q <= DB_RELEASE_WAIT;
            cnt_q   <= '0;
          end
        end
        DB_RELEASE_WAIT: begin
          if (!btn_sync) begin
            state_q <= DB_PRESSED;
          end else if (cnt_inc == CNT_LAST) begin
            state_q <= DB_RELEASED;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: state_q <= DB_RELEASED;
      endcase
    end
  end

endmodule

// File: rtl/pattern_sequencer.sv
// Selects and animates the active test pattern; all changes commit on the
// clock edge following frame_start so no frame mixes two patterns.
module pattern_sequencer
  import video_pkg::*;
#(
  parameter int NUM_PATTERNS    = 4,
  parameter int AUTO_FRAMES     = 300,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int H_ACTIVE        = video_pkg::H_ACTIVE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic             btn_n,
  input  logic             auto_en,
  input  logic             scroll_en,
  output logic [PAT_W-1:0] pattern_sel,
  output logic             pattern_changed,
  output logic [9:0]       scroll_x,
  output logic             btn_pressed
);

  localparam int FW = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;

  logic [1:0]       rst_sync_q;
  logic             rst_int_n;
  logic             press;
  logic             pending_q, pending_d;
  logic [FW-1:0]    frame_cnt_q, frame_cnt_d;
  logic [PAT_W-1:0] pattern_sel_q, pattern_sel_d;
  logic             changed_q, changed_d;
  logic [9:0]       scroll_q, scroll_d;
  logic             auto_term;
  logic             advance;

  // Assertion passes straight through; release is aligned to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .rst_n  (rst_int_n),
    .btn_n  (btn_n),
    .press_o(press)
  );

  assign auto_term = auto_en && (frame_cnt_q == FW'(AUTO_FRAMES - 1));
  // A press arriving on the boundary cycle itself is honoured there.
  assign advance   = frame_start && (pending_q || press || auto_term);

  always_comb begin
    pending_d     = pending_q | press;
    frame_cnt_d   = frame_cnt_q;
    pattern_sel_d = pattern_sel_q;
    changed_d     = 1'b0;
    scroll_d      = scroll_q;
    if (advance) begin
      pending_d     = 1'b0;
      frame_cnt_d   = '0;
      scroll_d      = '0;
      changed_d     = 1'b1;
      pattern_sel_d = (pattern_sel_q == PAT_W'(NUM_PATTERNS - 1)) ? '0 : pattern_sel_q + 1'b1;
    end else if (frame_start) begin
      if (auto_en) frame_cnt_d = frame_cnt_q + 1'b1;
      if (scroll_en) scroll_d = (scroll_q == 10'(H_ACTIVE - 1)) ? '0 : scroll_q + 1'b1;
    end
    if (!auto_en) frame_cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      pending_q     <= 1'b0;
      frame_cnt_q   <= '0;
      pattern_sel_q <= '0;
      changed_q     <= 1'b0;
      scroll_q      <= '0;
    end else begin
      pending_q     <= pending_d;
      frame_cnt_q   <= frame_cnt_d;
      pattern_sel_q <= pattern_sel_d;
      changed_q     <= changed_d;
      scroll_q      <= scroll_d;
    end
  end

  assign pattern_sel     = pattern_sel_q;
  assign pattern_changed = changed_q;
  assign scroll_x        = scroll_q;
  assign btn_pressed     = press;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed bench for pattern_sequencer with short debounce and auto intervals.
module tb_pattern_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_start;
  logic       btn_n;
  logic       auto_en;
  logic       scroll_en;
  logic [2:0] pattern_sel;
  logic       pattern_changed;
  logic [9:0] scroll_x;
  logic       btn_pressed;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pattern_sequencer #(
    .NUM_PATTERNS   (4),
    .AUTO_FRAMES    (3),
    .DEBOUNCE_CYCLES(16),
    .H_ACTIVE       (640)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .frame_start    (frame_start),
    .btn_n          (btn_n),
    .auto_en        (auto_en),
    .scroll_en      (scroll_en),
    .pattern_sel    (pattern_sel),
    .pattern_changed(pattern_changed),
    .scroll_x       (scroll_x),
    .btn_pressed    (btn_pressed)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    if (obs !== want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, want);
    end else begin
      $display("ok   %s = %0d", tag, obs);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle frame_start; returns at the negedge after the commit edge.
  task automatic frame();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  // Holds the button low for low_cycles, then released until the FSM settles.
  task automatic do_press(input int low_cycles, output int pulses, output int latency);
    pulses  = 0;
    latency = 0;
    btn_n   = 1'b0;
    for (int k = 1; k <= low_cycles + 30; k++) begin
      @(negedge clk);
      if (btn_pressed === 1'b1) begin
        pulses++;
        if (latency == 0) latency = k;
      end
      if (k == low_cycles) btn_n = 1'b1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses, latency, found;
    rst_n = 1'b0; frame_start = 1'b0; btn_n = 1'b1; auto_en = 1'b0; scroll_en = 1'b0;
    tick(3);
    check("rst_pattern_sel", pattern_sel, 0);
    check("rst_pattern_changed", pattern_changed, 0);
    check("rst_scroll_x", scroll_x, 0);
    check("rst_btn_pressed", btn_pressed, 0);
    rst_n = 1'b1;
    tick(4);

    do_press(10, pulses, latency);
    check("glitch_pulses", pulses, 0);

    do_press(20, pulses, latency);
    check("press_pulses", pulses, 1);
    check("press_latency", latency, 18);
    tick(5);
    check("press_uncommitted", pattern_sel, 0);
    check("press_no_change_pulse", pattern_changed, 0);
    frame();
    check("commit_sel", pattern_sel, 1);
    check("commit_changed", pattern_changed, 1);
    tick(1);
    check("commit_changed_drop", pattern_changed, 0);

    do_press(20, pulses, latency);
    do_press(20, pulses, latency);
    frame();
    check("double_press_sel", pattern_sel, 2);
    tick(2);
    frame();
    check("idle_frame_sel", pattern_sel, 2);
    check("idle_frame_changed", pattern_changed, 0);

    tick(1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_sel", pattern_sel, 0);
    check("async_rst_changed", pattern_changed, 0);
    check("async_rst_scroll", scroll_x, 0);
    check("async_rst_btn", btn_pressed, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(4);
    frame();
    check("post_rst_frame_sel", pattern_sel, 0);
    check("post_rst_frame_changed", pattern_changed, 0);

    for (int i = 1; i <= 4; i++) begin
      tick(2);
      do_press(20, pulses, latency);
      frame();
      check($sformatf("wrap_sel_%0d", i), pattern_sel, i % 4);
    end

    auto_en = 1'b1;
    tick(2);
    frame(); tick(2);
    check("auto_f1", pattern_sel, 0);
    frame(); tick(2);
    check("auto_f2", pattern_sel, 0);
    frame();
    check("auto_f3_sel", pattern_sel, 1);
    check("auto_f3_changed", pattern_changed, 1);
    tick(2);
    frame(); tick(2);
    frame(); tick(2);
    do_press(20, pulses, latency);
    frame();
    check("auto_and_press_sel", pattern_sel, 2);
    tick(2);
    frame(); tick(2);
    frame(); tick(2);
    check("auto_restart_hold", pattern_sel, 2);
    frame();
    check("auto_restart_sel", pattern_sel, 3);
    tick(2);
    frame(); tick(2);
    frame(); tick(2);
    auto_en = 1'b0;
    tick(1);
    auto_en = 1'b1;
    frame(); tick(2);
    frame(); tick(2);
    check("auto_reenable_hold", pattern_sel, 3);
    frame();
    check("auto_reenable_sel", pattern_sel, 0);
    auto_en = 1'b0;
    tick(2);

    btn_n = 1'b0;
    found = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (btn_pressed === 1'b1) begin
        found = 1;
        break;
      end
    end
    check("coincide_pulse_seen", found, 1);
    frame();
    check("coincide_sel", pattern_sel, 1);
    check("coincide_changed", pattern_changed, 1);
    btn_n = 1'b1;
    tick(30);
    frame();
    check("coincide_no_requeue", pattern_sel, 1);

    scroll_en = 1'b1;
    tick(2);
    for (int i = 1; i <= 640; i++) begin
      frame();
      check($sformatf("scroll_%0d", i), scroll_x, i % 640);
      tick(1);
    end
    check("scroll_no_advance", pattern_sel, 1);
    for (int i = 0; i < 5; i++) begin
      frame(); tick(1);
    end
    check("scroll_pre_advance", scroll_x, 5);
    do_press(20, pulses, latency);
    frame();
    check("advance_clears_scroll", scroll_x, 0);
    check("advance_sel", pattern_sel, 2);
    tick(1);
    frame();
    scroll_en = 1'b0;
    tick(1);
    frame();
    check("scroll_disabled_hold", scroll_x, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pattern_sequencer.md
Name: pattern_sequencer

Overview:
Controller that selects which test pattern the HDMI pixel pipeline renders, and animates it.
- Advances the pattern index on a debounced user button or automatically after a programmable number of frames.
- Commits every change only at a frame boundary, so a frame never shows a mixed pattern.
- Sits between the video timing generator (source of frame_start) and the pattern generators (consumers of pattern_sel and scroll_x).

Parameters:
- NUM_PATTERNS, 4: number of selectable patterns; legal range 2..8.
- AUTO_FRAMES, 300: frames per pattern in auto mode (5 s at 60 Hz); must be ≥ 1.
- DEBOUNCE_CYCLES, 250000: stable-input cycles required to accept a button edge (10 ms at 25 MHz).
- H_ACTIVE, 640: scroll_x wrap modulus.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- frame_start  in  1  single-cycle pulse at start of vertical blanking
- btn_n  in  1  raw asynchronous push button, active low
- auto_en  in  1  level; 1 = auto-advance enabled
- scroll_en  in  1  level; 1 = scroll_x advances each frame
- pattern_sel  out  3  current pattern index, 0..NUM_PATTERNS-1
- pattern_changed  out  1  single-cycle pulse when pattern_sel updates
- scroll_x  out  10  horizontal offset for animated patterns, 0..H_ACTIVE-1
- btn_pressed  out  1  single-cycle pulse on accepted press (debug/LED)

Behaviour:
- Reset (async assert, sync deassert inside block): pattern_sel=0, pattern_changed=0, scroll_x=0, btn_pressed=0, pending=0, frame counter=0, debounce FSM in RELEASED.
- Button path:
  - btn_n passes through a 2-flop synchronizer, then the debounce FSM.
  - RELEASED: synced input low → PRESS_WAIT, counter cleared.
  - PRESS_WAIT: input high → RELEASED. Counter reaches DEBOUNCE_CYCLES-1 with input still low → PRESSED, btn_pressed pulses for 1 cycle.
  - PRESSED: input high → RELEASE_WAIT, counter cleared.
  - RELEASE_WAIT: input low → PRESSED. Counter reaches DEBOUNCE_CYCLES-1 → RELEASED.
  - Glitches shorter than DEBOUNCE_CYCLES are ignored.
- Pending request:
  - btn_pressed sets pending.
  - Additional presses before the next frame_start do not queue; at most one advance per frame.
- Frame boundary (cycle where frame_start=1); the following takes effect on the next clock edge (1-cycle latency):
  - advance = pending OR (auto_en AND frame_cnt == AUTO_FRAMES-1).
  - If advance: pattern_sel = (pattern_sel == NUM_PATTERNS-1) ? 0 : pattern_sel+1; pattern_changed=1; pending=0; frame_cnt=0; scroll_x=0.
  - Else: frame_cnt increments only if auto_en. If scroll_en: scroll_x = (scroll_x == H_ACTIVE-1) ? 0 : scroll_x+1.
  - Button and auto terminal count in the same frame_start produce exactly one advance.
  - btn_pressed and frame_start in the same cycle: the press is honoured at this frame boundary.
- auto_en deassert clears frame_cnt immediately, so re-enabling starts a full AUTO_FRAMES interval.
- pattern_changed is low in every cycle without an advance. pattern_sel, scroll_x and pattern_changed are registered outputs.
- No frame_start: nothing ever commits; pending is held indefinitely.
- frame_cnt width is $clog2(AUTO_FRAMES); it never exceeds AUTO_FRAMES-1.

Decomposition:
- Shared package video_pkg: H_ACTIVE/V_ACTIVE constants, pattern index localparams (PAT_COLOR_BARS=0, PAT_GRADIENT=1, PAT_CHECKER=2, PAT_GRID=3), pattern index width.
- Sub-module button_debounce (synchronizer + 4-state FSM + counter, output press pulse) is natural and reusable for other board buttons.
- Top holds pending flag, frame counter and output registers.

Test Plan:
- Reset: rst_n low mid-operation with pattern_sel=2 → all outputs 0 asynchronously; after release, first frame_start with no request leaves pattern_sel=0.
- Debounce: DEBOUNCE_CYCLES=16; 10-cycle low glitch on btn_n → no btn_pressed. 20-cycle press → exactly one btn_pressed, 2+16 cycles after the falling edge.
- Frame-aligned commit: press accepted mid-frame → pattern_sel unchanged until frame_start, then updates next cycle with a 1-cycle pattern_changed. Two presses in one frame → single advance.
- Wrap: NUM_PATTERNS=4; four committed presses from 0 → sequence 1,2,3,0.
- Auto mode: AUTO_FRAMES=3, auto_en=1 → advance on every 3rd frame_start. Press coinciding with the terminal frame → one advance; frame_cnt restarts at 0.
- Scroll: H_ACTIVE=640, scroll_en=1, 640 frame_starts with no advance → scroll_x runs 1..639 then 0. Any advance resets scroll_x to 0.
